// File: rtl/regs_arbiter_if.sv
// regs_arbiter_if: requester-side bus of the register-file arbiter.
// Carries two independent command channels (valid/ready plus op, address
// and write data) and their registered response channels.
//   master : requester side (drives commands, receives ready and responses)
//   slave  : arbiter side   (receives commands, drives ready and responses)
// op encoding: 00 READ, 01 WRITE, 10 SWAP (a <-> a^1), 11 treated as READ.
interface regs_arbiter_if #(
  parameter int n     = 8,
  parameter int Rsize = 1
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [Rsize-1:0] req0_addr;
  logic [n-1:0]     req0_wdata;
  logic             rsp0_valid;
  logic [n-1:0]     rsp0_data;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [Rsize-1:0] req1_addr;
  logic [n-1:0]     req1_wdata;
  logic             rsp1_valid;
  logic [n-1:0]     rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_addr, req0_wdata,
    output req1_valid, req1_op, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_addr, req0_wdata,
    input  req1_valid, req1_op, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/regs_arbiter.sv
// regs_arbiter: shares a single-port, read-before-write register file
// (2^Rsize x n, registered read data) between two requesters.
// Accepts READ / WRITE / SWAP commands, sequences the register-file pins and
// returns one registered response per accepted command to its owner.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : two command/response channels, see regs_arbiter_if
//   rf_w            : register-file write enable
//   rf_Raddr        : register-file address
//   rf_Wdata        : register-file write data
//   rf_Rdata        : register-file read data (valid the cycle after address)
//   busy            : high whenever a command is in flight
// Latency from acceptance: READ/WRITE response visible 3 cycles later,
// SWAP response 5 cycles later. WRITE and SWAP return the old content of a.
module regs_arbiter #(
  parameter int n     = 8,
  parameter int Rsize = 1
) (
  input  logic             clk,
  input  logic             reset,
  regs_arbiter_if.slave    bus,
  output logic             rf_w,
  output logic [Rsize-1:0] rf_Raddr,
  output logic [n-1:0]     rf_Wdata,
  input  logic [n-1:0]     rf_Rdata,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAP   = 3'd2,
    S_RA  = 3'd3,
    S_RB  = 3'd4,
    S_WA  = 3'd5,
    S_WB  = 3'd6
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [1:0]       sel_op;
  logic [Rsize-1:0] sel_addr;
  logic [n-1:0]     sel_wdata;

  logic [1:0]       cmd_op;
  logic [Rsize-1:0] cmd_a;
  logic [Rsize-1:0] cmd_b;
  logic             cmd_owner;
  logic [n-1:0]     cmd_wdata;
  logic [n-1:0]     tmp_a;
  logic [n-1:0]     rsp_value;

  // Round-robin: a lone requester wins; on a tie the one not granted last
  // time wins. With nobody valid the grant still points at the next-in-turn
  // requester so its ready is already up when it arrives.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
    else if (bus.req0_valid)              grant = 1'b0;
    else                                  grant = ~last_grant;
  end

  assign bus.req0_ready = (state == IDLE) && !grant && !reset;
  assign bus.req1_ready = (state == IDLE) &&  grant && !reset;
  assign accept = (state == IDLE) && !reset &&
                  (grant ? bus.req1_valid : bus.req0_valid);

  assign sel_op    = grant ? bus.req1_op    : bus.req0_op;
  assign sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;

  // SWAP partner differs only in the LSB, so it is always in range.
  always_comb begin
    cmd_b    = cmd_a;
    cmd_b[0] = ~cmd_a[0];
  end

  assign busy = (state != IDLE);

  // Next state and register-file pins
  always_comb begin
    state_nx = state;
    rf_w     = 1'b0;
    rf_Raddr = cmd_a;
    rf_Wdata = '0;
    case (state)
      IDLE: begin
        if (accept) state_nx = (sel_op == OP_SWAP) ? S_RA : ISSUE;
      end
      ISSUE: begin
        // Reserved op falls through here as a plain read.
        if (cmd_op == OP_WRITE) begin
          rf_w     = 1'b1;
          rf_Wdata = cmd_wdata;
        end
        state_nx = CAP;
      end
      CAP: begin
        state_nx = IDLE;
      end
      S_RA: begin
        state_nx = S_RB;
      end
      S_RB: begin
        rf_Raddr = cmd_b;
        state_nx = S_WA;
      end
      S_WA: begin
        // rf_Rdata now carries old b (address presented in S_RB).
        rf_w     = 1'b1;
        rf_Wdata = rf_Rdata;
        state_nx = S_WB;
      end
      S_WB: begin
        rf_Raddr = cmd_b;
        rf_w     = 1'b1;
        rf_Wdata = tmp_a;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // WRITE returns the pre-write content captured in CAP; SWAP returns old a.
  assign rsp_value = (state == CAP) ? rf_Rdata : tmp_a;

  // Control state, command address and response channels
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      cmd_op         <= 2'b00;
      cmd_a          <= '0;
      cmd_owner      <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_data  <= '0;
      bus.rsp1_data  <= '0;
    end else begin
      state          <= state_nx;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      if (accept) begin
        cmd_op     <= sel_op;
        cmd_a      <= sel_addr;
        cmd_owner  <= grant;
        last_grant <= grant;
      end
      if (state == CAP || state == S_WB) begin
        if (cmd_owner) begin
          bus.rsp1_valid <= 1'b1;
          bus.rsp1_data  <= rsp_value;
        end else begin
          bus.rsp0_valid <= 1'b1;
          bus.rsp0_data  <= rsp_value;
        end
      end
    end
  end

  // Data-only registers: never observed before being loaded.
  always_ff @(posedge clk) begin
    if (accept)        cmd_wdata <= sel_wdata;
    if (state == S_RB) tmp_a     <= rf_Rdata;
  end

endmodule

// File: tb/tb_regs_arbiter.sv
// tb_regs_arbiter: bench for regs_arbiter with a behavioural register file.
// A reference model tracks memory contents, pending writes and due responses
// per cycle; directed sequences add hand-computed literal expectations.
// Note: a reset landing in S_WA of a SWAP leaves the file half swapped
// (a already holds old b, b is untouched). That is legal; the model keeps
// the write scheduled for S_WA and drops the S_WB one.
module tb_regs_arbiter;
  localparam int N  = 8;
  localparam int RS = 1;
  localparam int NW = 1 << RS;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] RV = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rf_w;
  logic [RS-1:0] rf_Raddr;
  logic [N-1:0]  rf_Wdata;
  logic [N-1:0]  rf_Rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  regs_arbiter_if #(.n(N), .Rsize(RS)) bus ();

  regs_arbiter #(.n(N), .Rsize(RS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rf_w     (rf_w),
    .rf_Raddr (rf_Raddr),
    .rf_Wdata (rf_Wdata),
    .rf_Rdata (rf_Rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port register file: synchronous read-before-write.
  logic [N-1:0] rf [0:NW-1] = '{default: '0};
  always @(posedge clk) begin
    rf_Rdata <= rf[rf_Raddr];
    if (rf_w) rf[rf_Raddr] <= rf_Wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int due; int owner; logic [N-1:0] data; } rsp_t;
  typedef struct packed { int due; logic [RS-1:0] addr; logic [N-1:0] data; } wr_t;

  rsp_t          rq[$];
  wr_t           wq[$];
  logic [N-1:0]  mem [0:NW-1] = '{default: '0};
  logic [N-1:0]  exp_d0 = '0;
  logic [N-1:0]  exp_d1 = '0;
  int            last_acc = -100;
  int            free_cyc = 0;
  int            last_gnt = 1;
  bit            chk_en = 1'b0;
  bit            ev0, ev1, ew, bsy, g0, g1;
  logic [RS-1:0] wa, ma, mb;
  logic [N-1:0]  wd;
  logic [1:0]    mop;
  int            mown;

  always @(negedge clk) begin
    ev0 = 0; ev1 = 0; ew = 0; wa = '0; wd = '0;
    foreach (rq[i]) if (rq[i].due == cyc) begin
      if (rq[i].owner == 0) begin ev0 = 1; exp_d0 = rq[i].data; end
      else                  begin ev1 = 1; exp_d1 = rq[i].data; end
    end
    foreach (wq[i]) if (wq[i].due == cyc) begin
      ew = 1; wa = wq[i].addr; wd = wq[i].data;
    end
    bsy = (cyc > last_acc) && (cyc < free_cyc);
    g0  = bus.req0_valid && (!bus.req1_valid || last_gnt == 1);
    g1  = bus.req1_valid && (!bus.req0_valid || last_gnt == 0);
    if (chk_en) begin
      check("m_rsp0_valid", bus.rsp0_valid, ev0);
      check("m_rsp1_valid", bus.rsp1_valid, ev1);
      check("m_rsp0_data", bus.rsp0_data, exp_d0);
      check("m_rsp1_data", bus.rsp1_data, exp_d1);
      check("m_rf_w", rf_w, ew);
      if (ew) begin
        check("m_rf_Raddr", rf_Raddr, wa);
        check("m_rf_Wdata", rf_Wdata, wd);
      end
      check("m_busy", busy, bsy);
      if (bus.req0_valid) check("m_req0_ready", bus.req0_ready, !reset && !bsy && g0);
      if (bus.req1_valid) check("m_req1_ready", bus.req1_ready, !reset && !bsy && g1);
    end
    foreach (wq[i]) if (wq[i].due == cyc) mem[wq[i].addr] = wq[i].data;
    for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].due <= cyc) wq.delete(i);
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
    if (reset) begin
      // Everything not yet performed is aborted by the reset edge.
      rq.delete(); wq.delete();
      exp_d0 = '0; exp_d1 = '0;
      free_cyc = 0; last_gnt = 1; chk_en = 1'b1;
    end else if (!bsy && (g0 || g1)) begin
      mown = g0 ? 0 : 1;
      mop  = g0 ? bus.req0_op   : bus.req1_op;
      ma   = g0 ? bus.req0_addr : bus.req1_addr;
      wd   = g0 ? bus.req0_wdata : bus.req1_wdata;
      mb   = ma ^ RS'(1);
      last_gnt = mown;
      last_acc = cyc;
      if (mop == SW) begin
        rq.push_back('{due: cyc + 5, owner: mown, data: mem[ma]});
        wq.push_back('{due: cyc + 3, addr: ma, data: mem[mb]});
        wq.push_back('{due: cyc + 4, addr: mb, data: mem[ma]});
        free_cyc = cyc + 5;
      end else begin
        rq.push_back('{due: cyc + 3, owner: mown, data: mem[ma]});
        if (mop == WR) wq.push_back('{due: cyc + 1, addr: ma, data: wd});
        free_cyc = cyc + 3;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input int who, input logic [1:0] op, input logic [RS-1:0] a,
                       input logic [N-1:0] d);
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic issue(input int who, input logic [1:0] op, input logic [RS-1:0] a,
                       input logic [N-1:0] d, output int acc);
    bit got;
    got = 0; acc = -1;
    drive(who, op, a, d);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if ((who == 0) ? bus.req0_ready : bus.req1_ready) begin got = 1; acc = cyc; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout who=%0d got=none expected=ready", who);
    end
    @(posedge clk); #1;
    drop(who);
  endtask

  task automatic wait_rsp(input string name, input int who, input int acc, input int lat,
                          input logic [N-1:0] d);
    bit got;
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if ((who == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
        got = 1;
        check({name, "_lat"}, cyc - acc, lat);
        check({name, "_data"}, (who == 0) ? bus.rsp0_data : bus.rsp1_data, d);
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout got=no_response expected=response", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int acc, acc2;
  int gnt_who[$];
  int gnt_cyc[$];

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 0; bus.req0_op = RD; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_op = RD; bus.req1_addr = '0; bus.req1_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rf_w", rf_w, 0);
    check("rst_rf_Raddr", rf_Raddr, 0);
    check("rst_rf_Wdata", rf_Wdata, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_data", bus.rsp1_data, 0);
    check("rst_ready0", bus.req0_ready, 0);
    @(posedge clk); #1 reset = 1'b0;

    // WRITE returns the previous content; READ sees the new one.
    issue(0, WR, 0, 8'hA5, acc); wait_rsp("wr1", 0, acc, 3, 8'h00);
    issue(0, WR, 0, 8'h3C, acc); wait_rsp("wr2", 0, acc, 3, 8'hA5);
    issue(0, RD, 0, 8'h00, acc); wait_rsp("rd1", 0, acc, 3, 8'h3C);

    // SWAP r0=0x11, r1=0x22 via requester 1.
    issue(0, WR, 0, 8'h11, acc); wait_rsp("wr3", 0, acc, 3, 8'h3C);
    issue(0, WR, 1, 8'h22, acc); wait_rsp("wr4", 0, acc, 3, 8'h00);
    issue(1, SW, 0, 8'h00, acc); wait_rsp("swap", 1, acc, 5, 8'h11);
    issue(0, RD, 0, 8'h00, acc); wait_rsp("swp_r0", 0, acc, 3, 8'h22);
    issue(1, RD, 1, 8'h00, acc); wait_rsp("swp_r1", 1, acc, 3, 8'h11);

    // Both requesters READ continuously from reset: alternating grants.
    do_reset(2);
    drive(0, RD, 0, 8'h00);
    drive(1, RD, 1, 8'h00);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("dual_pulse", bus.rsp0_valid && bus.rsp1_valid, 0);
      if (bus.req0_ready) begin gnt_who.push_back(0); gnt_cyc.push_back(cyc); end
      if (bus.req1_ready) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc); end
    end
    @(posedge clk); #1;
    drop(0); drop(1);
    check("rr_count", gnt_who.size(), 5);
    if (gnt_who.size() >= 4) begin
      check("rr_g0", gnt_who[0], 0);
      check("rr_g1", gnt_who[1], 1);
      check("rr_g2", gnt_who[2], 0);
      check("rr_g3", gnt_who[3], 1);
      check("rr_gap1", gnt_cyc[1] - gnt_cyc[0], 3);
      check("rr_gap2", gnt_cyc[2] - gnt_cyc[1], 3);
      check("rr_gap3", gnt_cyc[3] - gnt_cyc[2], 3);
    end
    repeat (6) @(posedge clk); #1;

    // Make requester 1 the last grantee, so requester 0 wins the next tie.
    issue(1, RD, 1, 8'h00, acc); wait_rsp("pre_r1", 1, acc, 3, 8'h11);

    // req1 waits through a req0 SWAP without losing its command.
    drive(0, SW, 0, 8'h00);
    drive(1, RD, 1, 8'h00);
    @(negedge clk);
    check("c0_ready0", bus.req0_ready, 1);
    check("c0_ready1", bus.req1_ready, 0);
    acc = cyc;
    @(posedge clk); #1;
    drop(0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("busy_ready1", bus.req1_ready, 0);
      check("busy_rf_w", rf_w, (k >= 3) ? 1 : 0);
    end
    @(negedge clk);
    check("c5_ready1", bus.req1_ready, 1);
    check("c5_rsp0_valid", bus.rsp0_valid, 1);
    check("c5_rsp0_data", bus.rsp0_data, 8'h22);
    acc2 = cyc;
    @(posedge clk); #1;
    drop(1);
    wait_rsp("held_r1", 1, acc2, 3, 8'h22);

    // Now r0=0x11, r1=0x22. Reset during S_WA of a SWAP.
    issue(0, SW, 0, 8'h00, acc);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_abort_rf_w", rf_w, 1);
    reset = 1'b1;
    drive(0, RD, 0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rf_w", rf_w, 0);
    check("abort_ready0", bus.req0_ready, 1);
    acc = cyc;
    @(posedge clk); #1;
    drop(0);
    wait_rsp("abort_r0", 0, acc, 3, 8'h22);
    issue(1, RD, 1, 8'h00, acc); wait_rsp("abort_r1", 1, acc, 3, 8'h22);

    // Reserved op executes as READ.
    issue(0, WR, 1, 8'h5A, acc); wait_rsp("wr5", 0, acc, 3, 8'h22);
    issue(0, RV, 1, 8'hFF, acc); wait_rsp("rsv", 0, acc, 3, 8'h5A);
    issue(1, RD, 1, 8'h00, acc); wait_rsp("rsv_after", 1, acc, 3, 8'h5A);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
